// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-outstanding AXI4 burst initiator between a local sync RAM and an AXI slave
// Bundle widths live in axi_burst_pkg; module parameters must agree with them.
package axi_burst_pkg;
  localparam int PKG_ID_W   = 4;
  localparam int PKG_ID_R   = 4;
  localparam int PKG_ADDR_W = 4;
  localparam int PKG_DATA_W = 32;
  localparam int PKG_STRB_W = 4;

  typedef struct packed {
    logic [PKG_ID_W-1:0]   aw_id;
    logic [PKG_ADDR_W-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  aw_valid;
    logic [PKG_DATA_W-1:0] w_data;
    logic [PKG_STRB_W-1:0] w_strb;
    logic                  w_last;
    logic                  w_valid;
    logic                  b_ready;
    logic [PKG_ID_R-1:0]   ar_id;
    logic [PKG_ADDR_W-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  ar_valid;
    logic                  r_ready;
  } axi_mosi_t;

  typedef struct packed {
    logic                  aw_ready;
    logic                  w_ready;
    logic [PKG_ID_W-1:0]   b_id;
    logic                  b_valid;
    logic                  ar_ready;
    logic [PKG_ID_R-1:0]   r_id;
    logic [PKG_DATA_W-1:0] r_data;
    logic                  r_last;
    logic                  r_valid;
  } axi_miso_t;
endpackage

module axi_burst_master
  import axi_burst_pkg::*;
#(
  parameter int ID_W_WIDTH     = PKG_ID_W,
  parameter int ID_R_WIDTH     = PKG_ID_R,
  parameter int ADDR_WIDTH     = PKG_ADDR_W,
  parameter int AXI_DATA_WIDTH = PKG_DATA_W,
  parameter int BYTE_WIDTH     = 8,
  parameter int RAM_ADDR_WIDTH = 4,
  parameter int MASTER_ID      = 0,
  parameter int BATCH_WIDTH    = AXI_DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]     cmd_axi_addr_i,
  input  logic [RAM_ADDR_WIDTH-1:0] cmd_ram_addr_i,
  input  logic [7:0]                cmd_len_i,
  output logic                      done_o,
  output logic                      err_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic [AXI_DATA_WIDTH-1:0] ram_wdata_o,
  output logic [BATCH_WIDTH-1:0]    ram_byte_en_o,
  input  logic [AXI_DATA_WIDTH-1:0] ram_rdata_i,
  output axi_mosi_t                 out_mosi_o,
  input  axi_miso_t                 out_miso_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W_FETCH, S_W_DATA, S_B, S_AR, S_R, S_DONE
  } state_t;

  localparam logic [2:0] AX_SIZE = 3'($clog2(BATCH_WIDTH));

  state_t                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [7:0]                len_q, len_d;
  logic [ADDR_WIDTH-1:0]     axi_addr_q, axi_addr_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_base_q, ram_base_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic                      held_q, held_d;
  logic                      err_q, err_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_cur;
  logic                      last_beat;

  assign ram_cur   = ram_base_q + cnt_q[RAM_ADDR_WIDTH-1:0];
  assign last_beat = (cnt_q == len_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      axi_addr_q <= '0;
      ram_base_q <= '0;
      data_q     <= '0;
      held_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      axi_addr_q <= axi_addr_d;
      ram_base_q <= ram_base_d;
      data_q     <= data_d;
      held_q     <= held_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    axi_addr_d    = axi_addr_q;
    ram_base_d    = ram_base_q;
    data_d        = data_q;
    held_d        = held_q;
    err_d         = err_q;
    cmd_ready_o   = 1'b0;
    done_o        = 1'b0;
    err_o         = 1'b0;
    ram_addr_o    = '0;
    ram_wdata_o   = '0;
    ram_byte_en_o = '0;
    out_mosi_o    = '0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_o = ~rst_i;
        if (cmd_valid_i) begin
          axi_addr_d = cmd_axi_addr_i;
          ram_base_d = cmd_ram_addr_i;
          len_d      = cmd_len_i;
          cnt_d      = '0;
          err_d      = 1'b0;
          state_d    = cmd_write_i ? S_AW : S_AR;
        end
      end
      S_AW: begin
        out_mosi_o.aw_valid = 1'b1;
        out_mosi_o.aw_id    = ID_W_WIDTH'(MASTER_ID);
        out_mosi_o.aw_addr  = axi_addr_q;
        out_mosi_o.aw_len   = len_q;
        out_mosi_o.aw_size  = AX_SIZE;
        out_mosi_o.aw_burst = 2'b01;
        if (out_miso_i.aw_ready) state_d = S_W_FETCH;
      end
      S_W_FETCH: begin
        ram_addr_o = ram_cur;
        held_d     = 1'b0;
        state_d    = S_W_DATA;
      end
      S_W_DATA: begin
        // RAM data arrives in the first W_DATA cycle; the register holds it across WREADY stalls.
        ram_addr_o         = ram_cur;
        out_mosi_o.w_valid = 1'b1;
        out_mosi_o.w_data  = held_q ? data_q : ram_rdata_i;
        out_mosi_o.w_strb  = '1;
        out_mosi_o.w_last  = last_beat;
        if (!held_q) begin
          data_d = ram_rdata_i;
          held_d = 1'b1;
        end
        if (out_miso_i.w_ready) begin
          held_d = 1'b0;
          if (last_beat) begin
            state_d = S_B;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = S_W_FETCH;
          end
        end
      end
      S_B: begin
        out_mosi_o.b_ready = 1'b1;
        if (out_miso_i.b_valid) begin
          err_d   = err_q | (out_miso_i.b_id != ID_W_WIDTH'(MASTER_ID));
          state_d = S_DONE;
        end
      end
      S_AR: begin
        out_mosi_o.ar_valid = 1'b1;
        out_mosi_o.ar_id    = ID_R_WIDTH'(MASTER_ID);
        out_mosi_o.ar_addr  = axi_addr_q;
        out_mosi_o.ar_len   = len_q;
        out_mosi_o.ar_size  = AX_SIZE;
        out_mosi_o.ar_burst = 2'b01;
        if (out_miso_i.ar_ready) state_d = S_R;
      end
      S_R: begin
        out_mosi_o.r_ready = 1'b1;
        ram_addr_o         = ram_cur;
        if (out_miso_i.r_valid) begin
          ram_wdata_o   = out_miso_i.r_data;
          ram_byte_en_o = '1;
          err_d = err_q | (out_miso_i.r_id != ID_R_WIDTH'(MASTER_ID))
                        | (out_miso_i.r_last != last_beat);
          if (last_beat) state_d = S_DONE;
          else           cnt_d   = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - scoreboard bench for axi_burst_master with a behavioural slave and RAM
module tb_axi_burst_master;
  import axi_burst_pkg::*;

  typedef struct packed { logic [3:0] addr; logic [7:0] len; } ax_t;
  typedef struct packed { logic [31:0] data; logic last; } wbeat_t;
  typedef struct packed { logic [3:0] addr; logic [31:0] data; } ramwr_t;
  typedef struct packed { logic err; logic gap; } done_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_axi_addr = '0;
  logic [3:0]  cmd_ram_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        done, err;
  logic [3:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byte_en;
  logic [31:0] ram_rdata;
  axi_mosi_t   mosi;
  axi_miso_t   miso;

  logic [31:0] mem [16];

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int done_seen = 0;
  int cyc = 0;
  int last_wr_cyc = 0;

  ax_t    exp_aw[$];
  ax_t    exp_ar[$];
  wbeat_t exp_w[$];
  ramwr_t exp_ram[$];
  done_t  exp_done[$];

  int          cfg_stall_beat = 0;
  int          cfg_stall_cycles = 0;
  logic [3:0]  cfg_bid = '0;
  bit          cfg_gaps = 0;
  logic [31:0] cfg_rbase = '0;
  int          cfg_rlast_beat = 0;

  axi_burst_master dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_axi_addr_i(cmd_axi_addr), .cmd_ram_addr_i(cmd_ram_addr), .cmd_len_i(cmd_len),
    .done_o(done), .err_o(err),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_byte_en_o(ram_byte_en),
    .ram_rdata_i(ram_rdata),
    .out_mosi_o(mosi), .out_miso_i(miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_byte_en != 4'h0) mem[ram_addr] <= ram_wdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // behavioural AXI slave, drives miso on the falling edge
  initial begin
    int w_beat, stall_used, r_left, r_beat;
    bit b_pend, r_tog;
    w_beat = 0; stall_used = 0; r_left = 0; r_beat = 0; b_pend = 0; r_tog = 0;
    miso = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        w_beat = 0; stall_used = 0; r_left = 0; r_beat = 0; b_pend = 0; r_tog = 0;
        miso = '0;
        continue;
      end
      miso.aw_ready = 1'b1;
      miso.ar_ready = 1'b1;
      miso.b_valid = 1'b0;
      if (b_pend && mosi.b_ready) begin
        miso.b_valid = 1'b1;
        miso.b_id    = cfg_bid;
        b_pend       = 0;
      end
      miso.w_ready = 1'b0;
      if (mosi.w_valid) begin
        if (w_beat == cfg_stall_beat && stall_used < cfg_stall_cycles) begin
          stall_used++;
        end else begin
          miso.w_ready = 1'b1;
          if (mosi.w_last) begin b_pend = 1; w_beat = 0; stall_used = 0; end
          else w_beat++;
        end
      end
      if (mosi.ar_valid) begin
        r_left = int'(mosi.ar_len) + 1; r_beat = 0; r_tog = 0;
      end
      miso.r_valid = 1'b0;
      miso.r_last  = 1'b0;
      if (mosi.r_ready && r_left > 0) begin
        if (!cfg_gaps || r_tog) begin
          miso.r_valid = 1'b1;
          miso.r_data  = cfg_rbase + 32'(r_beat);
          miso.r_last  = (r_beat == cfg_rlast_beat);
          miso.r_id    = 4'h0;
          r_beat++;
          r_left--;
        end
        r_tog = ~r_tog;
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a transfer
  initial begin
    bit          prev_stall;
    logic [31:0] prev_wdata;
    ax_t    a;
    wbeat_t w;
    ramwr_t r;
    done_t  d;
    prev_stall = 0; prev_wdata = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin prev_stall = 0; continue; end
      if (cmd_valid && cmd_ready) accepts++;
      if (prev_stall) begin
        check("w_valid_held", 64'(mosi.w_valid), 64'd1);
        check("w_data_stable", 64'(mosi.w_data), 64'(prev_wdata));
      end
      prev_stall = mosi.w_valid && !miso.w_ready;
      prev_wdata = mosi.w_data;
      if (mosi.aw_valid && miso.aw_ready) begin
        a = (exp_aw.size() > 0) ? exp_aw.pop_front() : '1;
        check("aw_addr_len", 64'({mosi.aw_addr, mosi.aw_len}), 64'(a));
        check("aw_id_size_burst", 64'({mosi.aw_id, mosi.aw_size, mosi.aw_burst}), 64'({4'h0, 3'd2, 2'b01}));
      end
      if (mosi.ar_valid && miso.ar_ready) begin
        a = (exp_ar.size() > 0) ? exp_ar.pop_front() : '1;
        check("ar_addr_len", 64'({mosi.ar_addr, mosi.ar_len}), 64'(a));
        check("ar_id_size_burst", 64'({mosi.ar_id, mosi.ar_size, mosi.ar_burst}), 64'({4'h0, 3'd2, 2'b01}));
      end
      if (mosi.w_valid && miso.w_ready) begin
        w = (exp_w.size() > 0) ? exp_w.pop_front() : '1;
        check("w_beat", 64'({mosi.w_data, mosi.w_last}), 64'(w));
        check("w_strb", 64'(mosi.w_strb), 64'hF);
      end
      if (ram_byte_en != 4'h0) begin
        r = (exp_ram.size() > 0) ? exp_ram.pop_front() : '1;
        check("ram_write", 64'({ram_addr, ram_wdata}), 64'(r));
        check("ram_byte_en", 64'(ram_byte_en), 64'hF);
        last_wr_cyc = cyc;
      end
      if (done) begin
        done_seen++;
        d = (exp_done.size() > 0) ? exp_done.pop_front() : '1;
        check("done_err", 64'(err), 64'(d.err));
        if (d.gap) check("done_after_last_beat", 64'(cyc - last_wr_cyc), 64'd1);
      end
    end
  end

  task automatic run_cmd(input logic wr, input logic [3:0] axi, input logic [3:0] ra,
                         input logic [7:0] len, input bit hold, output int lat);
    @(negedge clk);
    cmd_write = wr; cmd_axi_addr = axi; cmd_ram_addr = ra; cmd_len = len;
    cmd_valid = 1'b1;
    lat = 0;
    if (!hold) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
    end
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("cmd_timeout", 64'd0, 64'd1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int lat, acc0, done0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
    mem[3]  = 32'hA5A5_0001;
    mem[14] = 32'h1111_0014; mem[15] = 32'h1111_0015;
    mem[0]  = 32'h1111_0000; mem[1]  = 32'h1111_0001;
    mem[6]  = 32'h6666_0006;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_valids", 64'({mosi.aw_valid, mosi.w_valid, mosi.ar_valid, mosi.b_ready, mosi.r_ready}), 64'd0);
    check("rst_done_err", 64'({done, err}), 64'd0);
    check("rst_ram_byte_en", 64'(ram_byte_en), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

    // 1: single-beat write
    exp_aw.push_back('{4'd5, 8'd0});
    exp_w.push_back('{32'hA5A5_0001, 1'b1});
    exp_done.push_back('{1'b0, 1'b0});
    run_cmd(1'b1, 4'd5, 4'd3, 8'd0, 0, lat);
    check("write_len0_latency", 64'(lat), 64'd5);

    // 2: four-beat write wrapping RAM 14,15,0,1 with a stall on beat 1
    cfg_stall_beat = 1; cfg_stall_cycles = 2;
    exp_aw.push_back('{4'd9, 8'd3});
    exp_w.push_back('{32'h1111_0014, 1'b0});
    exp_w.push_back('{32'h1111_0015, 1'b0});
    exp_w.push_back('{32'h1111_0000, 1'b0});
    exp_w.push_back('{32'h1111_0001, 1'b1});
    exp_done.push_back('{1'b0, 1'b0});
    run_cmd(1'b1, 4'd9, 4'd14, 8'd3, 0, lat);
    cfg_stall_cycles = 0;

    // 3: four-beat read with RVALID gaps
    cfg_gaps = 1; cfg_rbase = 32'hC0DE_0000; cfg_rlast_beat = 3;
    exp_ar.push_back('{4'd2, 8'd3});
    for (int i = 0; i < 4; i++) exp_ram.push_back('{4'(8 + i), 32'hC0DE_0000 + 32'(i)});
    exp_done.push_back('{1'b0, 1'b1});
    run_cmd(1'b0, 4'd2, 4'd8, 8'd3, 0, lat);
    check("mem_after_read", 64'(mem[11]), 64'hC0DE_0003);

    // 4: early RLAST on a two-beat read
    cfg_gaps = 0; cfg_rbase = 32'hBEEF_0000; cfg_rlast_beat = 0;
    exp_ar.push_back('{4'd7, 8'd1});
    exp_ram.push_back('{4'd4, 32'hBEEF_0000});
    exp_ram.push_back('{4'd5, 32'hBEEF_0001});
    exp_done.push_back('{1'b1, 1'b1});
    run_cmd(1'b0, 4'd7, 4'd4, 8'd1, 0, lat);

    // 5: wrong BID with cmd_valid held for the whole burst
    cfg_bid = 4'h1;
    acc0 = accepts;
    exp_aw.push_back('{4'd0, 8'd0});
    exp_w.push_back('{32'h6666_0006, 1'b1});
    exp_done.push_back('{1'b1, 1'b0});
    run_cmd(1'b1, 4'd0, 4'd6, 8'd0, 1, lat);
    @(negedge clk);
    check("single_accept_held_valid", 64'(accepts - acc0), 64'd1);
    cfg_bid = 4'h0;

    // 6: reset while W_DATA is stalled
    cfg_stall_beat = 0; cfg_stall_cycles = 1000;
    done0 = done_seen;
    exp_aw.push_back('{4'd1, 8'd1});
    @(negedge clk);
    cmd_write = 1'b1; cmd_axi_addr = 4'd1; cmd_ram_addr = 4'd2; cmd_len = 8'd1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !mosi.w_valid; i++) @(negedge clk);
    check("w_valid_before_rst", 64'(mosi.w_valid), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_drops_w_valid", 64'(mosi.w_valid), 64'd0);
    check("rst_cmd_ready_low", 64'(cmd_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cfg_stall_cycles = 0;
    @(negedge clk);
    check("cmd_ready_after_mid_rst", 64'(cmd_ready), 64'd1);
    repeat (5) @(negedge clk);
    check("no_done_after_rst", 64'(done_seen - done0), 64'd0);

    check("aw_queue_empty", 64'(exp_aw.size()), 64'd0);
    check("ar_queue_empty", 64'(exp_ar.size()), 64'd0);
    check("w_queue_empty", 64'(exp_w.size()), 64'd0);
    check("ram_queue_empty", 64'(exp_ram.size()), 64'd0);
    check("done_queue_empty", 64'(exp_done.size()), 64'd0);
    check("total_accepts", 64'(accepts), 64'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
